// File: rtl/risc_v_mem_bus_arbiter.sv
// Round-robin arbiter sharing the risc_v_mem_ctrl bus between instruction fetch and the LSU.
// Faulting requests are answered locally and never reach the bus.
module risc_v_mem_bus_arbiter #(
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] mem_bus_rd_addr,
  output logic [31:0] mem_bus_wr_addr,
  output logic        mem_bus_read,
  output logic        mem_bus_write,
  output logic [31:0] mem_bus_wr_data,
  input  logic [31:0] mem_bus_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_t      state;
  logic        last_owner;  // 1 = LSU
  logic        owner_lsu;
  logic        is_write;
  logic [3:0]  cnt;
  logic        pick_if;
  logic        pick_lsu;
  logic [31:0] req_addr;
  logic        req_we;
  logic        req_fault;

  function automatic logic addr_fault(input logic [31:0] a, input logic from_lsu,
                                      input logic we);
    logic in_text, in_data, in_mmio;
    in_text = (a >= 32'h0040_0000) && (a <= 32'h0FFF_FFFF);
    in_data = (a >= 32'h1000_0000) && (a <= 32'h7FFF_FFFF);
    in_mmio = (a >= 32'hFFFF_0000);
    if (a[1:0] != 2'b00) return 1'b1;
    if (!from_lsu) return !in_text;
    return !(in_text || in_data || in_mmio) || (we && in_text);
  endfunction

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    pick_if  = 1'b0;
    pick_lsu = 1'b0;
    if (state == IDLE && rst_n) begin
      if (if_req && lsu_req) begin
        pick_lsu = ~last_owner;
        pick_if  = last_owner;
      end else begin
        pick_lsu = lsu_req;
        pick_if  = if_req;
      end
    end
  end

  assign if_gnt    = pick_if;
  assign lsu_gnt   = pick_lsu;
  assign req_addr  = pick_lsu ? lsu_addr : if_addr;
  assign req_we    = pick_lsu & lsu_we;
  assign req_fault = addr_fault(req_addr, pick_lsu, req_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_owner      <= 1'b0;
      owner_lsu       <= 1'b0;
      is_write        <= 1'b0;
      cnt             <= '0;
      if_rvalid       <= 1'b0;
      if_rdata        <= '0;
      if_err          <= 1'b0;
      lsu_rvalid      <= 1'b0;
      lsu_rdata       <= '0;
      lsu_err         <= 1'b0;
      mem_bus_rd_addr <= '0;
      mem_bus_wr_addr <= '0;
      mem_bus_read    <= 1'b0;
      mem_bus_write   <= 1'b0;
      mem_bus_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_if || pick_lsu) begin
            last_owner <= pick_lsu;
            owner_lsu  <= pick_lsu;
            is_write   <= req_we;
            if (req_fault) begin
              state <= RESP;
              if (pick_lsu) begin
                lsu_rvalid <= 1'b1;
                lsu_err    <= 1'b1;
              end else begin
                if_rvalid <= 1'b1;
                if_err    <= 1'b1;
              end
            end else begin
              state <= ACCESS;
              if (req_we) begin
                mem_bus_write   <= 1'b1;
                mem_bus_wr_addr <= req_addr;
                mem_bus_wr_data <= lsu_wdata;
                cnt             <= WR_CNT;
              end else begin
                mem_bus_read    <= 1'b1;
                mem_bus_rd_addr <= req_addr;
                cnt             <= RD_CNT;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state           <= RESP;
            mem_bus_read    <= 1'b0;
            mem_bus_write   <= 1'b0;
            mem_bus_rd_addr <= '0;
            mem_bus_wr_addr <= '0;
            mem_bus_wr_data <= '0;
            if (owner_lsu) begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= is_write ? 32'h0 : mem_bus_rd_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_bus_rd_data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          if_rvalid  <= 1'b0;
          if_rdata   <= '0;
          if_err     <= 1'b0;
          lsu_rvalid <= 1'b0;
          lsu_rdata  <= '0;
          lsu_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mem_bus_arbiter.sv
// Directed bench for risc_v_mem_bus_arbiter: one instance with RD_LAT=1/WR_LAT=3 and one
// with RD_LAT=4/WR_LAT=1 sharing the same stimulus.
module tb_risc_v_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [31:0] mem_bus_rd_data = '0;

  logic        if_gnt, if_rvalid, if_err, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] if_rdata, lsu_rdata;
  logic [31:0] mem_bus_rd_addr, mem_bus_wr_addr, mem_bus_wr_data;
  logic        mem_bus_read, mem_bus_write;

  logic        b_if_gnt, b_if_rvalid, b_if_err, b_lsu_gnt, b_lsu_rvalid, b_lsu_err;
  logic [31:0] b_if_rdata, b_lsu_rdata;
  logic [31:0] b_mem_bus_rd_addr, b_mem_bus_wr_addr, b_mem_bus_wr_data;
  logic        b_mem_bus_read, b_mem_bus_write;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  risc_v_mem_bus_arbiter #(.RD_LAT(1), .WR_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_bus_rd_addr(mem_bus_rd_addr), .mem_bus_wr_addr(mem_bus_wr_addr),
    .mem_bus_read(mem_bus_read), .mem_bus_write(mem_bus_write),
    .mem_bus_wr_data(mem_bus_wr_data), .mem_bus_rd_data(mem_bus_rd_data)
  );

  risc_v_mem_bus_arbiter #(.RD_LAT(4), .WR_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata), .if_err(b_if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(b_lsu_gnt), .lsu_rvalid(b_lsu_rvalid), .lsu_rdata(b_lsu_rdata),
    .lsu_err(b_lsu_err),
    .mem_bus_rd_addr(b_mem_bus_rd_addr), .mem_bus_wr_addr(b_mem_bus_wr_addr),
    .mem_bus_read(b_mem_bus_read), .mem_bus_write(b_mem_bus_write),
    .mem_bus_wr_data(b_mem_bus_wr_data), .mem_bus_rd_data(mem_bus_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Returns 1 for an LSU grant, 0 for IF, -1 if nothing was granted within the budget.
  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      if (if_gnt || lsu_gnt) begin
        who = lsu_gnt ? 1 : 0;
        break;
      end
      cyc();
    end
  endtask

  task automatic lsu_fault(input string tag, input logic [31:0] addr, input logic we);
    lsu_req  = 1'b1;
    lsu_we   = we;
    lsu_addr = addr;
    #1;
    chk({tag, "_gnt"}, {31'b0, lsu_gnt}, 32'd1);
    cyc();
    lsu_req = 1'b0;
    #1;
    chk({tag, "_rvalid"}, {31'b0, lsu_rvalid}, 32'd1);
    chk({tag, "_err"}, {31'b0, lsu_err}, 32'd1);
    chk({tag, "_busidle"}, {30'b0, mem_bus_read, mem_bus_write}, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata, 32'd0);
    cyc();
    chk({tag, "_pulse"}, {31'b0, lsu_rvalid}, 32'd0);
  endtask

  initial begin
    int who;
    int exp_who;
    logic seen;

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {26'b0, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, mem_bus_read,
                        mem_bus_write}, 32'd0);
    apply_reset();
    chk("rst_rd_addr", mem_bus_rd_addr, 32'd0);

    // IF read, RD_LAT=1
    if_req = 1'b1;
    if_addr = 32'h0040_0000;
    mem_bus_rd_data = 32'h0050_0093;
    #1;
    chk("t1_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("t1_lsu_gnt", {31'b0, lsu_gnt}, 32'd0);
    cyc();
    if_req = 1'b0;
    #1;
    chk("t1_read", {31'b0, mem_bus_read}, 32'd1);
    chk("t1_rd_addr", mem_bus_rd_addr, 32'h0040_0000);
    chk("t1_early_rvalid", {31'b0, if_rvalid}, 32'd0);
    cyc();
    chk("t1_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("t1_rdata", if_rdata, 32'h0050_0093);
    chk("t1_err", {31'b0, if_err}, 32'd0);
    chk("t1_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
    chk("t1_bus_released", {31'b0, mem_bus_read}, 32'd0);
    cyc();
    chk("t1_pulse", {31'b0, if_rvalid}, 32'd0);

    // Round-robin from reset with both requesters held
    apply_reset();
    mem_bus_rd_data = 32'h0BAD_F00D;
    if_req = 1'b1;
    if_addr = 32'h0040_0000;
    lsu_req = 1'b1;
    lsu_we = 1'b0;
    lsu_addr = 32'h1001_0000;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_who = (k % 2 == 0) ? 1 : 0;
      wait_gnt(who);
      chk("rr_owner", who, exp_who);
      chk("rr_one_gnt", {31'b0, if_gnt & lsu_gnt}, 32'd0);
      cyc();
      cyc();
      chk("rr_owner_rvalid", {30'b0, if_rvalid, lsu_rvalid},
          (exp_who == 1) ? 32'd1 : 32'd2);
      chk("rr_rdata", (exp_who == 1) ? lsu_rdata : if_rdata, 32'h0BAD_F00D);
      if (k == 3) begin
        if_req = 1'b0;
        lsu_req = 1'b0;
      end
      cyc();
    end

    // LSU write, WR_LAT=3
    lsu_req = 1'b1;
    lsu_we = 1'b1;
    lsu_addr = 32'h7FFF_EFFC;
    lsu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t3_gnt", {31'b0, lsu_gnt}, 32'd1);
    cyc();
    lsu_req = 1'b0;
    lsu_we = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_write", {30'b0, mem_bus_write, mem_bus_read}, 32'd2);
      chk("t3_wr_addr", mem_bus_wr_addr, 32'h7FFF_EFFC);
      chk("t3_wr_data", mem_bus_wr_data, 32'hDEAD_BEEF);
      chk("t3_no_rvalid", {31'b0, lsu_rvalid}, 32'd0);
      cyc();
    end
    chk("t3_write_done", {31'b0, mem_bus_write}, 32'd0);
    chk("t3_wr_addr_clr", mem_bus_wr_addr, 32'd0);
    chk("t3_rvalid", {31'b0, lsu_rvalid}, 32'd1);
    chk("t3_err", {31'b0, lsu_err}, 32'd0);
    chk("t3_rdata", lsu_rdata, 32'd0);
    cyc();

    // Faults
    lsu_fault("f_unmapped", 32'h0000_0100, 1'b0);
    lsu_fault("f_misalign", 32'h1001_0002, 1'b0);
    lsu_fault("f_text_wr", 32'h0040_0004, 1'b1);
    lsu_we = 1'b0;
    if_req = 1'b1;
    if_addr = 32'hFFFF_0000;
    #1;
    chk("f_if_gnt", {31'b0, if_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    #1;
    chk("f_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("f_if_err", {31'b0, if_err}, 32'd1);
    chk("f_if_busidle", {31'b0, mem_bus_read}, 32'd0);
    cyc();

    // MMIO read is legal
    mem_bus_rd_data = 32'h1234_5678;
    lsu_req = 1'b1;
    lsu_addr = 32'hFFFF_0010;
    #1;
    chk("m_gnt", {31'b0, lsu_gnt}, 32'd1);
    cyc();
    lsu_req = 1'b0;
    #1;
    chk("m_read", {31'b0, mem_bus_read}, 32'd1);
    chk("m_rd_addr", mem_bus_rd_addr, 32'hFFFF_0010);
    cyc();
    chk("m_rvalid", {31'b0, lsu_rvalid}, 32'd1);
    chk("m_err", {31'b0, lsu_err}, 32'd0);
    chk("m_rdata", lsu_rdata, 32'h1234_5678);
    cyc();

    // Reset in the middle of a RD_LAT=4 access
    apply_reset();
    lsu_req = 1'b1;
    lsu_addr = 32'h1000_0000;
    #1;
    chk("r_gnt", {31'b0, b_lsu_gnt}, 32'd1);
    cyc();
    lsu_req = 1'b0;
    cyc();
    chk("r_read_mid", {31'b0, b_mem_bus_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_read_cleared", {31'b0, b_mem_bus_read}, 32'd0);
    chk("r_addr_cleared", b_mem_bus_rd_addr, 32'd0);
    chk("r_rvalid_cleared", {31'b0, b_lsu_rvalid}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      seen = seen | b_lsu_rvalid | b_if_rvalid | b_mem_bus_read;
    end
    chk("r_no_stale", {31'b0, seen}, 32'd0);
    mem_bus_rd_data = 32'hA5A5_0001;
    if_req = 1'b1;
    if_addr = 32'h0040_0000;
    lsu_req = 1'b1;
    lsu_addr = 32'h1000_0004;
    #1;
    chk("r_next_gnt", {30'b0, b_if_gnt, b_lsu_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    lsu_req = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("r_hold", {31'b0, b_mem_bus_read}, 32'd1);
      cyc();
    end
    chk("r_rvalid", {31'b0, b_lsu_rvalid}, 32'd1);
    chk("r_rdata", b_lsu_rdata, 32'hA5A5_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
